cordic_sqrt_checker: RTL and testbench
======================================

// Module: cordic_sqrt_checker
// PURPOSE
// - Downstream of the CORDIC core in MODE 3 (sqrt). It consumes the core's results and scores them against expected sqrt values.
// - Expected values enter alongside each issued operand. They are delayed to match the core's pipeline latency, then compared with a tolerance.
// - Keeps pass/fail/max-error statistics and records the first failing vector index. This makes on-chip regression of the sqrt path possible.
// PARAMETERS
// - WIDTH       23     result width (16 + 7 guard bits); expected value width is WIDTH-1
// - ORDER       12     CORDIC iteration count
// - LATENCY     13     cycles from operand issue to result at core output (ORDER+1)
// - CNTR_WIDTH  16     width of vector index and statistics counters
// - NUM_VEC     65536  vectors per run (1..2^CNTR_WIDTH)
// - TOL         2      max |expected - result| counted as pass (LSBs)
// PORTS
// - CLK               in   1            clock; all logic on posedge
// - RESET             in   1            synchronous reset, active-high
// - start             in   1            begin a run: clear stats, enter RUN
// - in_valid          in   1            operand issued to CORDIC this cycle
// - exp_value         in   WIDTH-1      signed expected sqrt for the operand issued this cycle
// - res_value         in   WIDTH        signed CORDIC sqrt result (results[WIDTH-1:0])
// - busy              out  1            high in RUN or DRAIN
// - done              out  1            high in DONE
// - pass_cnt          out  CNTR_WIDTH   results within TOL (saturating)
// - fail_cnt          out  CNTR_WIDTH   results outside TOL (saturating)
// - first_fail_valid  out  1            a failure has been recorded this run
// - first_fail_idx    out  CNTR_WIDTH   index (0-based, issue order) of first failure
// - max_abs_err       out  WIDTH        largest |diff| seen this run (saturating)
// - err_pulse         out  1            one-cycle pulse on each failing compare
// BEHAVIOUR
// - Reset: state=IDLE. All outputs 0. The delay line valid bits are cleared; delay line data is don't-care.
// - FSM: IDLE --start--> RUN. RUN --issued==NUM_VEC--> DRAIN. DRAIN --checked==NUM_VEC--> DONE. DONE --start--> RUN.
//   start is ignored in RUN/DRAIN. RESET has priority over everything, including mid-run.
// - Issue: in RUN each in_valid pushes {1, exp_value} into the delay line and increments issued.
//   in_valid is ignored outside RUN and after issued reaches NUM_VEC; 0 is pushed instead.
// - Alignment: an entry pushed at cycle t is compared with res_value sampled at cycle t+LATENCY.
//   The delay line shifts every cycle, regardless of in_valid.
// - Compare: diff = sext(exp_value, WIDTH+1) - sext(res_value, WIDTH+1). absd = |diff|, saturated to 2^(WIDTH-1)-1.
//   Pass iff absd <= TOL. Only taken when the delayed valid bit is 1.
// - On compare: checked++. Exactly one of pass_cnt/fail_cnt increments; counters hold at all-ones.
//   max_abs_err = max(max_abs_err, absd). On fail: err_pulse=1 the next cycle.
//   If !first_fail_valid, then first_fail_idx=checked (pre-increment value) and first_fail_valid=1.
// - Stats outputs are registered and update 1 cycle after the compare cycle. done rises in the same cycle as the last stats update.
// - start in IDLE/DONE: counters, max_abs_err, first_fail_* and the delay line valid bits clear on that edge. RUN starts next cycle.
// - Gaps in in_valid are allowed; alignment is by the pipeline shift, not by count.
// - Stats hold in DONE until next start or RESET.
// STRUCTURE
// - Package cordic_chk_pkg: WIDTH/ORDER/LATENCY defaults, state enum {IDLE,RUN,DRAIN,DONE}, sat_abs function.
// - Sub-module cordic_align_delay #(DW, DEPTH): shift register of {valid, data}, synchronous clear of the valid bits.
// - Top: FSM, issue/check counters, comparator, stats registers.
// TESTING
// - RESET held 3 cycles mid-DRAIN -> all outputs 0, state IDLE, no err_pulse afterwards.
// - NUM_VEC=4, exp=res-delayed {0x100,0x200,0x300,0x400} -> pass_cnt=4, fail_cnt=0, max_abs_err=0, done 1 cycle after 4th compare.
// - Vector 2 has res = exp+3 (TOL=2) -> fail_cnt=1, first_fail_idx=2, err_pulse once, max_abs_err=3.
// - Fails at idx 1 and 3 -> first_fail_idx stays 1, fail_cnt=2.
// - in_valid gaps (issue at cycles 0,2,5,6) -> each compare exactly LATENCY cycles later, checked=4.
// - Extremes: exp=0x3FFFFF, res=0x400000 -> absd saturates, counted fail, no overflow.
// - start pulsed in RUN -> ignored. start in DONE -> stats cleared, new run matches the first.

Source files
------------

// File: rtl/cordic_chk_pkg.sv
// Shared defaults, FSM state type and saturating-abs helper for the CORDIC sqrt checker.
package cordic_chk_pkg;

   localparam int WIDTH_DEF      = 23;
   localparam int ORDER_DEF      = 12;
   localparam int LATENCY_DEF    = ORDER_DEF + 1;
   localparam int CNTR_WIDTH_DEF = 16;
   localparam int NUM_VEC_DEF    = 65536;
   localparam int TOL_DEF        = 2;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

   // Magnitude of a signed value, clipped to lim.
   function automatic logic [63:0] sat_abs(input logic signed [63:0] d, input logic [63:0] lim);
      logic [63:0] mag;
      mag = d[63] ? $unsigned(-d) : $unsigned(d);
      return (mag > lim) ? lim : mag;
   endfunction

endpackage

// File: rtl/cordic_align_delay.sv
// Fixed-depth shift register of {valid, data} aligning expected values with the core's result stream.
module cordic_align_delay #(
   parameter int DW    = 22,
   parameter int DEPTH = 13
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   output logic [DW-1:0] out_data
);

   logic [DEPTH-1:0] vld_q, vld_d;
   logic [DW-1:0]    dat_q [DEPTH];
   logic [DW-1:0]    dat_d [DEPTH];

   always_comb begin
      vld_d[0] = in_valid;
      dat_d[0] = in_data;
      for (int i = 1; i < DEPTH; i++) begin
         vld_d[i] = vld_q[i-1];
         dat_d[i] = dat_q[i-1];
      end
      if (clr) vld_d = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) vld_q <= '0;
      else     vld_q <= vld_d;
   end

   // NOTE: the data stages carry no reset; their contents are ignored whenever the matching valid bit is low.
   always_ff @(posedge clk) begin
      dat_q <= dat_d;
   end

   assign out_valid = vld_q[DEPTH-1];
   assign out_data  = dat_q[DEPTH-1];

endmodule

// File: rtl/cordic_sqrt_checker.sv
// Scores CORDIC sqrt results against latency-aligned expected values and keeps per-run statistics.
module cordic_sqrt_checker
   import cordic_chk_pkg::*;
#(
   parameter int WIDTH      = WIDTH_DEF,
   parameter int ORDER      = ORDER_DEF,
   parameter int LATENCY    = ORDER + 1,
   parameter int CNTR_WIDTH = CNTR_WIDTH_DEF,
   parameter int NUM_VEC    = NUM_VEC_DEF,
   parameter int TOL        = TOL_DEF
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  start,
   input  logic                  in_valid,
   input  logic [WIDTH-2:0]      exp_value,
   input  logic [WIDTH-1:0]      res_value,
   output logic                  busy,
   output logic                  done,
   output logic [CNTR_WIDTH-1:0] pass_cnt,
   output logic [CNTR_WIDTH-1:0] fail_cnt,
   output logic                  first_fail_valid,
   output logic [CNTR_WIDTH-1:0] first_fail_idx,
   output logic [WIDTH-1:0]      max_abs_err,
   output logic                  err_pulse
);

   localparam int                    CW1       = CNTR_WIDTH + 1;
   localparam logic [CNTR_WIDTH:0]   NUM_VEC_C = CW1'(NUM_VEC);
   localparam logic [CNTR_WIDTH-1:0] CNT_MAX   = '1;
   localparam logic [63:0]           ABS_LIM   = (64'd1 << (WIDTH - 1)) - 64'd1;
   localparam logic [WIDTH-1:0]      TOL_C     = WIDTH'(TOL);

   state_e                state_q, state_d;
   logic [CNTR_WIDTH:0]   issued_q, issued_d, checked_q, checked_d;
   logic [CNTR_WIDTH-1:0] pass_cnt_q, pass_cnt_d, fail_cnt_q, fail_cnt_d;
   logic [CNTR_WIDTH-1:0] first_fail_idx_q, first_fail_idx_d;
   logic                  first_fail_valid_q, first_fail_valid_d;
   logic [WIDTH-1:0]      max_abs_err_q, max_abs_err_d;
   logic                  err_pulse_q, err_pulse_d;

   logic                  clr, push_valid, dly_valid, is_pass;
   logic [WIDTH-2:0]      push_data, dly_exp;
   logic signed [WIDTH:0] diff;
   logic [WIDTH-1:0]      absd;

   assign clr        = start && (state_q == IDLE || state_q == DONE);
   assign push_valid = (state_q == RUN) && in_valid && (issued_q != NUM_VEC_C);
   assign push_data  = push_valid ? exp_value : '0;

   cordic_align_delay #(.DW(WIDTH - 1), .DEPTH(LATENCY)) u_delay (
      .clk      (CLK),
      .rst      (RESET),
      .clr      (clr),
      .in_valid (push_valid),
      .in_data  (push_data),
      .out_valid(dly_valid),
      .out_data (dly_exp)
   );

   // One extra bit over the result width so the subtraction can never wrap.
   assign diff    = $signed({{2{dly_exp[WIDTH-2]}}, dly_exp}) - $signed({res_value[WIDTH-1], res_value});
   assign absd    = WIDTH'(sat_abs({{(63 - WIDTH){diff[WIDTH]}}, diff}, ABS_LIM));
   assign is_pass = (absd <= TOL_C);

   // NOTE: every combinational output gets its hold value first, so no path through this block can infer a latch.
   always_comb begin
      issued_d           = issued_q;
      checked_d          = checked_q;
      pass_cnt_d         = pass_cnt_q;
      fail_cnt_d         = fail_cnt_q;
      first_fail_valid_d = first_fail_valid_q;
      first_fail_idx_d   = first_fail_idx_q;
      max_abs_err_d      = max_abs_err_q;
      err_pulse_d        = 1'b0;
      if (clr) begin
         issued_d           = '0;
         checked_d          = '0;
         pass_cnt_d         = '0;
         fail_cnt_d         = '0;
         first_fail_valid_d = 1'b0;
         first_fail_idx_d   = '0;
         max_abs_err_d      = '0;
      end else begin
         if (push_valid) issued_d = issued_q + CW1'(1);
         if (dly_valid) begin
            checked_d = checked_q + CW1'(1);
            if (absd > max_abs_err_q) max_abs_err_d = absd;
            if (is_pass) begin
               if (pass_cnt_q != CNT_MAX) pass_cnt_d = pass_cnt_q + CNTR_WIDTH'(1);
            end else begin
               if (fail_cnt_q != CNT_MAX) fail_cnt_d = fail_cnt_q + CNTR_WIDTH'(1);
               err_pulse_d = 1'b1;
               if (!first_fail_valid_q) begin
                  first_fail_valid_d = 1'b1;
                  first_fail_idx_d   = checked_q[CNTR_WIDTH-1:0];
               end
            end
         end
      end
   end

   // DRAIN looks at checked_d so done rises together with the final stats update.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (issued_q == NUM_VEC_C) state_d = DRAIN;
         DRAIN:   if (checked_d == NUM_VEC_C) state_d = DONE;
         DONE:    if (start) state_d = RUN;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q            <= IDLE;
         issued_q           <= '0;
         checked_q          <= '0;
         pass_cnt_q         <= '0;
         fail_cnt_q         <= '0;
         first_fail_valid_q <= 1'b0;
         first_fail_idx_q   <= '0;
         max_abs_err_q      <= '0;
         err_pulse_q        <= 1'b0;
      end else begin
         state_q            <= state_d;
         issued_q           <= issued_d;
         checked_q          <= checked_d;
         pass_cnt_q         <= pass_cnt_d;
         fail_cnt_q         <= fail_cnt_d;
         first_fail_valid_q <= first_fail_valid_d;
         first_fail_idx_q   <= first_fail_idx_d;
         max_abs_err_q      <= max_abs_err_d;
         err_pulse_q        <= err_pulse_d;
      end
   end

   assign busy             = (state_q == RUN) || (state_q == DRAIN);
   assign done             = (state_q == DONE);
   assign pass_cnt         = pass_cnt_q;
   assign fail_cnt         = fail_cnt_q;
   assign first_fail_valid = first_fail_valid_q;
   assign first_fail_idx   = first_fail_idx_q;
   assign max_abs_err      = max_abs_err_q;
   assign err_pulse        = err_pulse_q;

endmodule

// File: tb/tb_cordic_sqrt_checker.sv
// Directed bench for cordic_sqrt_checker with a 4-vector run and the default 13-cycle latency.
module tb_cordic_sqrt_checker;

   localparam int LAT = 13;
   localparam logic [22:0] JUNK_RES = 23'h155555;

   logic        CLK = 1'b0;
   logic        RESET, start, in_valid;
   logic [21:0] exp_value;
   logic [22:0] res_value;
   logic        busy, done, first_fail_valid, err_pulse;
   logic [15:0] pass_cnt, fail_cnt, first_fail_idx;
   logic [22:0] max_abs_err;

   int tests_run    = 0;
   int tests_failed = 0;

   int          iss [4];
   logic [21:0] ex  [4];
   logic [22:0] rs  [4];
   int          done_cycle, err_count, err_first_cycle;
   int          cmp_cycle [$];

   cordic_sqrt_checker #(.NUM_VEC(4)) dut (
      .CLK(CLK), .RESET(RESET), .start(start), .in_valid(in_valid),
      .exp_value(exp_value), .res_value(res_value), .busy(busy), .done(done),
      .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .first_fail_valid(first_fail_valid),
      .first_fail_idx(first_fail_idx), .max_abs_err(max_abs_err), .err_pulse(err_pulse)
   );

   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Runs one 4-vector pass; an extra in_valid one cycle after the last issue must be ignored.
   task automatic run_vectors(input int start_pulse_cycle);
      int last, seen;
      last = iss[3];
      start = 1'b1;
      step();
      start = 1'b0;
      tests_run++; if (busy !== 1'b1 || pass_cnt !== 0 || fail_cnt !== 0 || max_abs_err !== 0 || first_fail_valid !== 1'b0) begin tests_failed++; $display("FAIL start_clear: busy=%0b pass=%0d fail=%0d max=%0h ffv=%0b want 1/0/0/0/0", busy, pass_cnt, fail_cnt, max_abs_err, first_fail_valid); end
      done_cycle = -1; err_count = 0; err_first_cycle = -1; seen = 0;
      cmp_cycle.delete();
      for (int c = 0; c <= last + LAT + 3; c++) begin
         in_valid  = 1'b0;
         exp_value = 22'h2AAAAA;
         res_value = JUNK_RES;
         for (int k = 0; k < 4; k++) begin
            if (c == iss[k]) begin in_valid = 1'b1; exp_value = ex[k]; end
            if (c == iss[k] + LAT) res_value = rs[k];
         end
         if (c == last + 1) begin in_valid = 1'b1; exp_value = 22'h0; end
         start = (c == start_pulse_cycle);
         step();
         if (err_pulse === 1'b1) begin
            err_count++;
            if (err_first_cycle < 0) err_first_cycle = c;
         end
         if (done === 1'b1 && done_cycle < 0) done_cycle = c;
         if (int'(pass_cnt) + int'(fail_cnt) > seen) begin
            cmp_cycle.push_back(c);
            seen = int'(pass_cnt) + int'(fail_cnt);
         end
      end
      start = 1'b0; in_valid = 1'b0;
   endtask

   task automatic test_reset();
      RESET = 1'b1; start = 1'b0; in_valid = 1'b0; exp_value = '0; res_value = '0;
      repeat (3) step();
      RESET = 1'b0;
      step();
      tests_run++; if (busy !== 1'b0 || done !== 1'b0) begin tests_failed++; $display("FAIL reset_state: busy=%0b done=%0b want 0/0", busy, done); end
      tests_run++; if (pass_cnt !== 0 || fail_cnt !== 0 || first_fail_idx !== 0) begin tests_failed++; $display("FAIL reset_cnts: pass=%0d fail=%0d idx=%0d want 0", pass_cnt, fail_cnt, first_fail_idx); end
      tests_run++; if (max_abs_err !== 0 || first_fail_valid !== 1'b0 || err_pulse !== 1'b0) begin tests_failed++; $display("FAIL reset_misc: max=%0h ffv=%0b errp=%0b want 0", max_abs_err, first_fail_valid, err_pulse); end
   endtask

   task automatic test_all_pass();
      iss = '{0, 1, 2, 3};
      ex  = '{22'h100, 22'h200, 22'h300, 22'h400};
      rs  = '{23'h100, 23'h200, 23'h300, 23'h400};
      run_vectors(-1);
      tests_run++; if (pass_cnt !== 16'd4 || fail_cnt !== 16'd0) begin tests_failed++; $display("FAIL all_pass_cnts: pass=%0d fail=%0d want 4/0", pass_cnt, fail_cnt); end
      tests_run++; if (max_abs_err !== 0 || first_fail_valid !== 1'b0 || err_count != 0) begin tests_failed++; $display("FAIL all_pass_err: max=%0h ffv=%0b pulses=%0d want 0", max_abs_err, first_fail_valid, err_count); end
      tests_run++; if (done_cycle != 16 || busy !== 1'b0) begin tests_failed++; $display("FAIL all_pass_done: done_cycle=%0d busy=%0b want 16/0", done_cycle, busy); end
   endtask

   task automatic test_single_fail();
      iss = '{0, 1, 2, 3};
      ex  = '{22'h100, 22'h200, 22'h300, 22'h400};
      rs  = '{23'h0FE, 23'h200, 23'h303, 23'h400};
      run_vectors(-1);
      tests_run++; if (pass_cnt !== 16'd3 || fail_cnt !== 16'd1) begin tests_failed++; $display("FAIL single_cnts: pass=%0d fail=%0d want 3/1", pass_cnt, fail_cnt); end
      tests_run++; if (first_fail_valid !== 1'b1 || first_fail_idx !== 16'd2) begin tests_failed++; $display("FAIL single_idx: ffv=%0b idx=%0d want 1/2", first_fail_valid, first_fail_idx); end
      tests_run++; if (err_count != 1 || err_first_cycle != 15) begin tests_failed++; $display("FAIL single_pulse: pulses=%0d at=%0d want 1 at 15", err_count, err_first_cycle); end
      tests_run++; if (max_abs_err !== 23'd3) begin tests_failed++; $display("FAIL single_max: got %0d want 3", max_abs_err); end
   endtask

   task automatic test_two_fails();
      iss = '{0, 1, 2, 3};
      ex  = '{22'h100, 22'h200, 22'h300, 22'h400};
      rs  = '{23'h100, 23'h1FB, 23'h300, 23'h404};
      run_vectors(-1);
      tests_run++; if (pass_cnt !== 16'd2 || fail_cnt !== 16'd2) begin tests_failed++; $display("FAIL two_cnts: pass=%0d fail=%0d want 2/2", pass_cnt, fail_cnt); end
      tests_run++; if (first_fail_idx !== 16'd1 || err_count != 2 || err_first_cycle != 14) begin tests_failed++; $display("FAIL two_idx: idx=%0d pulses=%0d first=%0d want 1/2/14", first_fail_idx, err_count, err_first_cycle); end
      tests_run++; if (max_abs_err !== 23'd5) begin tests_failed++; $display("FAIL two_max: got %0d want 5", max_abs_err); end
   endtask

   task automatic test_gaps();
      iss = '{0, 2, 5, 6};
      ex  = '{22'h011, 22'h022, 22'h033, 22'h044};
      rs  = '{23'h011, 23'h022, 23'h033, 23'h044};
      run_vectors(-1);
      tests_run++; if (pass_cnt !== 16'd4 || fail_cnt !== 16'd0) begin tests_failed++; $display("FAIL gaps_cnts: pass=%0d fail=%0d want 4/0", pass_cnt, fail_cnt); end
      tests_run++; if (cmp_cycle.size() != 4) begin tests_failed++; $display("FAIL gaps_ncmp: got %0d want 4", cmp_cycle.size()); end
      for (int k = 0; k < 4 && k < cmp_cycle.size(); k++) begin
         tests_run++; if (cmp_cycle[k] != iss[k] + LAT) begin tests_failed++; $display("FAIL gaps_align%0d: cycle=%0d want %0d", k, cmp_cycle[k], iss[k] + LAT); end
      end
      tests_run++; if (done_cycle != 19) begin tests_failed++; $display("FAIL gaps_done: done_cycle=%0d want 19", done_cycle); end
   endtask

   task automatic test_extremes();
      iss = '{0, 1, 2, 3};
      ex  = '{22'h3FFFFF, 22'h200000, 22'h1FFFFF, 22'h000001};
      rs  = '{23'h400000, 23'h3FFFFF, 23'h1FFFFF, 23'h7FFFFF};
      run_vectors(-1);
      tests_run++; if (pass_cnt !== 16'd2 || fail_cnt !== 16'd2) begin tests_failed++; $display("FAIL ext_cnts: pass=%0d fail=%0d want 2/2", pass_cnt, fail_cnt); end
      tests_run++; if (max_abs_err !== 23'h3FFFFF) begin tests_failed++; $display("FAIL ext_max: got %0h want 3fffff", max_abs_err); end
      tests_run++; if (first_fail_idx !== 16'd0 || first_fail_valid !== 1'b1) begin tests_failed++; $display("FAIL ext_idx: idx=%0d ffv=%0b want 0/1", first_fail_idx, first_fail_valid); end
   endtask

   task automatic test_start_in_run();
      iss = '{0, 1, 2, 3};
      ex  = '{22'h100, 22'h200, 22'h300, 22'h400};
      rs  = '{23'h100, 23'h200, 23'h300, 23'h400};
      run_vectors(2);
      tests_run++; if (pass_cnt !== 16'd4 || fail_cnt !== 16'd0 || done_cycle != 16) begin tests_failed++; $display("FAIL start_in_run: pass=%0d fail=%0d done_cycle=%0d want 4/0/16", pass_cnt, fail_cnt, done_cycle); end
   endtask

   task automatic test_restart_from_done();
      test_extremes();
      repeat (5) step();
      tests_run++; if (done !== 1'b1 || fail_cnt !== 16'd2 || max_abs_err !== 23'h3FFFFF) begin tests_failed++; $display("FAIL done_hold: done=%0b fail=%0d max=%0h want 1/2/3fffff", done, fail_cnt, max_abs_err); end
      test_all_pass();
   endtask

   task automatic test_reset_mid_drain();
      start = 1'b1;
      step();
      start = 1'b0;
      err_count = 0;
      for (int c = 0; c < 10; c++) begin
         in_valid  = (c < 4);
         exp_value = 22'h100;
         res_value = JUNK_RES;
         step();
      end
      in_valid = 1'b0;
      tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL pre_reset_busy: got %0b want 1", busy); end
      RESET = 1'b1;
      repeat (3) step();
      tests_run++; if (busy !== 1'b0 || done !== 1'b0 || pass_cnt !== 0 || fail_cnt !== 0 || max_abs_err !== 0 || first_fail_valid !== 1'b0 || err_pulse !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_outs: busy=%0b done=%0b pass=%0d fail=%0d max=%0h ffv=%0b want all 0", busy, done, pass_cnt, fail_cnt, max_abs_err, first_fail_valid); end
      RESET = 1'b0;
      for (int c = 0; c < 20; c++) begin
         step();
         if (err_pulse === 1'b1) err_count++;
      end
      tests_run++; if (err_count != 0 || fail_cnt !== 0 || busy !== 1'b0) begin tests_failed++; $display("FAIL post_reset_quiet: pulses=%0d fail=%0d busy=%0b want 0/0/0", err_count, fail_cnt, busy); end
   endtask

   initial begin
      test_reset();
      test_all_pass();
      test_single_fail();
      test_two_fails();
      test_gaps();
      test_start_in_run();
      test_restart_from_done();
      test_reset_mid_drain();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
